// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access modes, FSM states and size decode.
package load_store_unit_pkg;

  localparam logic [1:0] ModeByte = 2'b00;
  localparam logic [1:0] ModeHalf = 2'b01;
  localparam logic [1:0] ModeWord = 2'b10;
  localparam logic [1:0] ModeRsvd = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StResp
  } lsu_state_e;

  // Reserved mode maps to 1 byte; it always faults before any access is issued.
  function automatic logic [2:0] mode_bytes(input logic [1:0] mode);
    case (mode)
      ModeHalf: mode_bytes = 3'd2;
      ModeWord: mode_bytes = 3'd4;
      default:  mode_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the little-endian assembled load value.
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  mode_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (mode_i)
      ModeByte: data_o = {{24{data_i[7] & ~unsigned_i}}, data_i[7:0]};
      ModeHalf: data_o = {{16{data_i[15] & ~unsigned_i}}, data_i[15:0]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: one request at a time onto an 8-bit synchronous-read port.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 41,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_mode,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q;
  logic              write_q;
  logic [1:0]        mode_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        k_q;
  logic [31:0]       asm_q;

  logic [2:0]        req_n;
  logic [ADDR_W:0]   req_end;
  logic              req_fault;
  logic [1:0]        last_k;
  logic [1:0]        k_nxt;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [31:0]       asm_merge;
  logic [31:0]       ext_data;

  // One extra bit on the end address catches wrap-around past 2^ADDR_W.
  assign req_n     = mode_bytes(req_mode);
  assign req_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_n) - (ADDR_W+1)'(1);
  assign req_fault = (req_mode == ModeRsvd) || req_end[ADDR_W] ||
                     (req_end >= (ADDR_W+1)'(MEM_BYTES));
  assign last_k    = 2'(mode_bytes(mode_q) - 3'd1);
  assign k_nxt     = k_q + 2'd1;

  // Read data lags its issue by one cycle, so lane k_q-1 lands while issuing k_q.
  always_comb begin
    cap_en    = ((state_q == StRead) && (k_q != 2'd0)) || (state_q == StDrain);
    cap_idx   = (state_q == StDrain) ? k_q : k_q - 2'd1;
    asm_merge = asm_q;
    if (cap_en) asm_merge[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  lsu_extend u_extend (
    .data_i     (asm_merge),
    .mode_i     (mode_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_re     <= 1'b0;
      write_q    <= 1'b0;
      mode_q     <= ModeByte;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      k_q        <= '0;
      asm_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            mode_q    <= req_mode;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            k_q       <= '0;
            asm_q     <= '0;
            req_ready <= 1'b0;
            if (req_fault) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write) begin
              state_q   <= StWrite;
              mem_addr  <= req_addr;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata[7:0];
            end else begin
              state_q  <= StRead;
              mem_addr <= req_addr;
              mem_re   <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (k_q == last_k) begin
            state_q    <= StResp;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
          end else begin
            k_q       <= k_nxt;
            mem_addr  <= addr_q + ADDR_W'(k_nxt);
            mem_wdata <= wdata_q[{k_nxt, 3'b000} +: 8];
          end
        end
        StRead: begin
          asm_q <= asm_merge;
          if (k_q == last_k) begin
            state_q  <= StDrain;
            mem_re   <= 1'b0;
            mem_addr <= '0;
          end else begin
            k_q      <= k_nxt;
            mem_addr <= addr_q + ADDR_W'(k_nxt);
          end
        end
        StDrain: begin
          state_q    <= StResp;
          asm_q      <= asm_merge;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= ext_data;
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 41-byte synchronous-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_mode;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:40];
  logic        mem_init;

  int n_checks = 0;
  int n_err    = 0;

  int          lat;
  logic        got_fault;
  logic [31:0] got_rdata;
  int          we_cnt, re_cnt, both_cnt, ready_bad;
  logic [31:0] we_addr [4];
  logic [7:0]  we_data [4];
  logic [31:0] re_addr [4];

  always #5 clk = ~clk;

  load_store_unit #(
    .MEM_BYTES (41),
    .ADDR_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_mode     (req_mode),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_fault   (resp_fault),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 41; i++) mem[i] <= 8'(8'h10 + i);
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we && (mem_addr < 32'd41)) mem[mem_addr[5:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= (mem_addr < 32'd41) ? mem[mem_addr[5:0]] : 8'h00;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, then log strobes and the response for up to 10 cycles.
  task automatic run_req(input logic w, input logic [1:0] m, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_mode = m; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got_fault = 1'b0; got_rdata = '0;
    we_cnt = 0; re_cnt = 0; both_cnt = 0; ready_bad = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (req_ready) ready_bad++;
      if (mem_we && mem_re) both_cnt++;
      if (mem_we) begin
        if (we_cnt < 4) begin
          we_addr[we_cnt] = mem_addr;
          we_data[we_cnt] = mem_wdata;
        end
        we_cnt++;
      end
      if (mem_re) begin
        if (re_cnt < 4) re_addr[re_cnt] = mem_addr;
        re_cnt++;
      end
      if (resp_valid) begin
        lat = i; got_fault = resp_fault; got_rdata = resp_rdata;
      end
    end
  endtask

  initial begin
    int resp_seen;
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_mode = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp", {29'd0, resp_valid, resp_fault, 1'b0}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_maddr", mem_addr, 32'd0);
    check_eq("rst_strobe", {24'd0, mem_wdata}, 32'd0);
    check_eq("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    rst = 1'b0; mem_init = 1'b0;

    // Store word 0xDEADBEEF at 8
    run_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
    check_eq("sw_lat", 32'(lat), 32'd5);
    check_eq("sw_fault", 32'(got_fault), 32'd0);
    check_eq("sw_we_cnt", 32'(we_cnt), 32'd4);
    check_eq("sw_re_cnt", 32'(re_cnt), 32'd0);
    check_eq("sw_bytes", {we_data[3], we_data[2], we_data[1], we_data[0]}, 32'hDEADBEEF);
    check_eq("sw_addr0", we_addr[0], 32'd8);
    check_eq("sw_addr3", we_addr[3], 32'd11);
    check_eq("sw_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEADBEEF);
    check_eq("sw_ready", 32'(ready_bad), 32'd0);

    run_req(1'b0, 2'b00, 1'b0, 32'd8, 32'h0);
    check_eq("lb_lat", 32'(lat), 32'd3);
    check_eq("lb_rdata", got_rdata, 32'hFFFFFFEF);
    check_eq("lb_re_cnt", 32'(re_cnt), 32'd1);
    check_eq("lb_re_addr", re_addr[0], 32'd8);

    run_req(1'b0, 2'b01, 1'b1, 32'd9, 32'h0);
    check_eq("lhu_lat", 32'(lat), 32'd4);
    check_eq("lhu_rdata", got_rdata, 32'h0000ADBE);
    check_eq("lhu_re_addr1", re_addr[1], 32'd10);

    run_req(1'b0, 2'b01, 1'b0, 32'd9, 32'h0);
    check_eq("lh_rdata", got_rdata, 32'hFFFFADBE);

    // Last in-range word 37..40
    run_req(1'b0, 2'b10, 1'b0, 32'd37, 32'h0);
    check_eq("lw_top_lat", 32'(lat), 32'd6);
    check_eq("lw_top_fault", 32'(got_fault), 32'd0);
    check_eq("lw_top_rdata", got_rdata, 32'h38373635);
    check_eq("lw_top_both", 32'(both_cnt), 32'd0);

    run_req(1'b0, 2'b00, 1'b1, 32'd40, 32'h0);
    check_eq("lbu_40_rdata", got_rdata, 32'h00000038);

    run_req(1'b0, 2'b10, 1'b0, 32'd38, 32'h0);
    check_eq("lw38_lat", 32'(lat), 32'd1);
    check_eq("lw38_fault", 32'(got_fault), 32'd1);
    check_eq("lw38_rdata", got_rdata, 32'd0);
    check_eq("lw38_strobes", 32'(we_cnt + re_cnt), 32'd0);

    run_req(1'b1, 2'b11, 1'b0, 32'd0, 32'h12345678);
    check_eq("rsvd_lat", 32'(lat), 32'd1);
    check_eq("rsvd_fault", 32'(got_fault), 32'd1);
    check_eq("rsvd_strobes", 32'(we_cnt + re_cnt), 32'd0);
    check_eq("rsvd_mem0", {24'd0, mem[0]}, 32'h10);

    run_req(1'b1, 2'b00, 1'b0, 32'd41, 32'hAA);
    check_eq("sb41_fault", 32'(got_fault), 32'd1);
    check_eq("sb41_strobes", 32'(we_cnt), 32'd0);

    run_req(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    check_eq("wrap_fault", 32'(got_fault), 32'd1);
    check_eq("wrap_lat", 32'(lat), 32'd1);

    // Reset during the second byte of a word store at 0
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_mode = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'h44332211;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_we1", 32'(mem_we), 32'd1);
    @(negedge clk);
    check_eq("abort_addr2", mem_addr, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    check_eq("abort_ready", 32'(req_ready), 32'd1);
    resp_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    check_eq("abort_no_resp", 32'(resp_seen), 32'd0);
    check_eq("abort_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h13122211);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_mode = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = '0;
    @(posedge clk);
    lat = 0; ready_bad = 0; got_rdata = '0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (req_ready) ready_bad++;
      if (resp_valid) begin
        lat = i; got_rdata = resp_rdata;
      end
    end
    check_eq("b2b_lat", 32'(lat), 32'd6);
    check_eq("b2b_rdata", got_rdata, 32'h13122211);
    check_eq("b2b_busy_ready", 32'(ready_bad), 32'd0);
    @(negedge clk);
    check_eq("b2b_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("b2b_second_re", {31'd0, mem_re}, 32'd1);
    check_eq("b2b_second_ready", 32'(req_ready), 32'd0);
    lat = 0; got_rdata = '0;
    for (int i = 2; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; got_rdata = resp_rdata;
      end
    end
    check_eq("b2b2_lat", 32'(lat), 32'd6);
    check_eq("b2b2_rdata", got_rdata, 32'h13122211);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
